// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage access unit: memory aluop codes, FSM states,
// byte-lane constants and small decode helpers.
package mem_access_pkg;

    localparam logic [7:0] ExeLbOp  = 8'b1110_0000;
    localparam logic [7:0] ExeLhOp  = 8'b1110_0001;
    localparam logic [7:0] ExeLwOp  = 8'b1110_0011;
    localparam logic [7:0] ExeLbuOp = 8'b1110_0100;
    localparam logic [7:0] ExeLhuOp = 8'b1110_0101;
    localparam logic [7:0] ExeSbOp  = 8'b1110_1000;
    localparam logic [7:0] ExeShOp  = 8'b1110_1001;
    localparam logic [7:0] ExeSwOp  = 8'b1110_1011;

    localparam logic [3:0] SelByte0  = 4'b0001;
    localparam logic [3:0] SelHalfLo = 4'b0011;
    localparam logic [3:0] SelHalfHi = 4'b1100;
    localparam logic [3:0] SelWord   = 4'b1111;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } mem_state_e;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {ExeLbOp, ExeLbuOp, ExeLhOp, ExeLhuOp, ExeLwOp};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {ExeSbOp, ExeShOp, ExeSwOp};
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] addr);
        case (op)
            ExeLhOp, ExeLhuOp, ExeShOp: return addr[0];
            ExeLwOp, ExeSwOp:           return addr != 2'b00;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Picks the addressed byte/halfword out of a little-endian bus word and extends it
// according to the load opcode.
module mem_access_load_align
    import mem_access_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = rdata[8*addr +: 8];
        lane_half = addr[1] ? rdata[31:16] : rdata[15:0];
        case (aluop)
            ExeLbOp:  data = {{24{lane_byte[7]}}, lane_byte};
            ExeLbuOp: data = {24'd0, lane_byte};
            ExeLhOp:  data = {{16{lane_half[15]}}, lane_half};
            ExeLhuOp: data = {16'd0, lane_half};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage access unit: turns load/store aluops into word-bus transactions, stalls the
// pipeline while the access is outstanding and holds the result until MEM/WB captures it.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [31:0] mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    output logic [31:0] wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        stallreq,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        align_err,
    output logic        bus_err
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      result_q;
    logic             result_wreg_q;
    logic             align_held_q;

    logic        op_load, op_store, op_misaligned, op_go;
    logic [3:0]  sel_d;
    logic [31:0] wdata_d;
    logic [31:0] load_data;

    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[3:0]};

    assign op_load       = is_load(mem_aluop);
    assign op_store      = is_store(mem_aluop);
    assign op_misaligned = (op_load | op_store) & is_misaligned(mem_aluop, mem_mem_addr[1:0]);
    assign op_go         = (op_load | op_store) & ~op_misaligned;

    mem_access_load_align u_load_align (
        .aluop (mem_aluop),
        .addr  (mem_mem_addr[1:0]),
        .rdata (bus_rdata),
        .data  (load_data)
    );

    // Narrow stores replicate the datum across the word so any selected lane carries it.
    always_comb begin
        sel_d   = SelWord;
        wdata_d = '0;
        case (mem_aluop)
            ExeSbOp: begin
                sel_d   = SelByte0 << mem_mem_addr[1:0];
                wdata_d = {4{mem_reg2[7:0]}};
            end
            ExeShOp: begin
                sel_d   = mem_mem_addr[1] ? SelHalfHi : SelHalfLo;
                wdata_d = {2{mem_reg2[15:0]}};
            end
            ExeSwOp: wdata_d = mem_reg2;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        wb_wd    = mem_wd;
        wb_wreg  = mem_wreg;
        wb_wdata = mem_wdata;
        stallreq = 1'b0;
        case (state_q)
            StIdle: begin
                if (op_misaligned) begin
                    wb_wreg = 1'b0;
                end else if (op_go) begin
                    wb_wreg  = 1'b0;
                    stallreq = 1'b1;
                    state_d  = StAccess;
                end
            end
            StAccess: begin
                wb_wreg  = 1'b0;
                stallreq = 1'b1;
                if (bus_ack || cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                wb_wreg  = op_load & mem_wreg & result_wreg_q;
                wb_wdata = op_load ? result_q : mem_wdata;
                if (!stall[4]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            result_q      <= '0;
            result_wreg_q <= 1'b0;
            align_held_q  <= 1'b0;
            align_err     <= 1'b0;
            bus_err       <= 1'b0;
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_sel       <= '0;
            bus_wdata     <= '0;
        end else begin
            state_q <= state_d;
            bus_err <= 1'b0;
            // One pulse per presented op, even if EX/MEM holds it for several cycles.
            align_err    <= (state_q == StIdle) && op_misaligned && !align_held_q;
            align_held_q <= (state_q == StIdle) && op_misaligned && stall[4];
            case (state_q)
                StIdle: begin
                    if (op_go) begin
                        bus_req   <= 1'b1;
                        bus_we    <= op_store;
                        bus_addr  <= {mem_mem_addr[31:2], 2'b00};
                        bus_sel   <= sel_d;
                        bus_wdata <= wdata_d;
                        cnt_q     <= '0;
                    end
                end
                StAccess: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus_ack) begin
                        bus_req       <= 1'b0;
                        result_q      <= op_load ? load_data : '0;
                        result_wreg_q <= op_load;
                    end else if (cnt_q == CntLast) begin
                        bus_req       <= 1'b0;
                        result_q      <= '0;
                        result_wreg_q <= 1'b0;
                        bus_err       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
